// File: rtl/gba_line_cache.sv
// gba_line_cache: ring of captured GBA lines; returns the 3x3 neighbourhood around (rdLine, curPxl).
// Define GBA_LINE_CACHE_NEIGHBOUR_EN for the 4-bank 3x3 build; otherwise 2 banks, centre pixel only.
module gba_line_cache #(
  parameter int LINE_PX = 240,
  parameter int LINES   = 160
) (
  input  logic        pxlClk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic [7:0]  wrPxl,
  input  logic [7:0]  wrRed,
  input  logic [7:0]  wrGreen,
  input  logic [7:0]  wrBlue,
  input  logic        wrLineDone,
  input  logic        wrFrameStart,
  input  logic        rdFrameStart,
  input  logic        nextLine,
  input  logic        cacheUpdate,
  input  logic [7:0]  curPxl,
  output logic [71:0] prevLineOut,
  output logic [71:0] curLineOut,
  output logic [71:0] nextLineOut,
  output logic        sameLine,
  output logic        overflow
);

`ifdef GBA_LINE_CACHE_NEIGHBOUR_EN
  localparam int         NB      = 4;
  localparam int         BW      = 2;
  localparam logic [8:0] OVF_GAP = 9'd3;
`else
  localparam int         NB      = 2;
  localparam int         BW      = 1;
  localparam logic [8:0] OVF_GAP = 9'd2;
`endif
  localparam logic [7:0] LAST_PX = 8'(LINE_PX - 1);
  localparam logic [7:0] LAST_LN = 8'(LINES - 1);
  localparam logic [8:0] N_LINES = 9'(LINES);

  logic [23:0]   mem [NB][LINE_PX];
  logic [7:0]    wr_line, rd_line, rd_nxt;
  logic [8:0]    wr_done, done_nxt;
  logic [7:0]    p, pp, pn;
  logic [BW-1:0] bw, bc, bp, bn;
  logic          adv, wr_over;

  always_comb begin
    rd_nxt = rd_line;
    if (rdFrameStart)
      rd_nxt = '0;
    else if (nextLine && !sameLine && rd_line != LAST_LN)
      rd_nxt = rd_line + 8'd1;

    done_nxt = wr_done;
    if (wrFrameStart)
      done_nxt = '0;
    else if (wrLineDone && wr_done != N_LINES)
      done_nxt = wr_done + 9'd1;

    // Decision is taken on the counters as they stand after this edge, so a
    // simultaneous rdFrameStart already sees rdLine = 0.
`ifdef GBA_LINE_CACHE_NEIGHBOUR_EN
    adv = (({1'b0, rd_nxt} + 9'd2) < done_nxt) ||
          ((({1'b0, rd_nxt} + 9'd2) == N_LINES) && (done_nxt == N_LINES));
`else
    adv = (({1'b0, rd_nxt} + 9'd1) < done_nxt) || (rd_nxt == LAST_LN);
`endif

    wr_over = wrEn && ({1'b0, wr_line} >= ({1'b0, rd_line} + OVF_GAP));
  end

  always_comb begin
    p  = (curPxl > LAST_PX) ? LAST_PX : curPxl;
    bw = wr_line[BW-1:0];
    bc = rd_line[BW-1:0];
`ifdef GBA_LINE_CACHE_NEIGHBOUR_EN
    pp = (p == 8'd0) ? p : p - 8'd1;
    pn = (p == LAST_PX) ? p : p + 8'd1;
    bp = (rd_line == 8'd0) ? bc : BW'(rd_line - 8'd1);
    bn = (rd_line == LAST_LN) ? bc : BW'(rd_line + 8'd1);
`else
    pp = p;
    pn = p;
    bp = bc;
    bn = bc;
`endif
  end

  // Line storage has no reset; its contents are meaningless until written.
  always_ff @(posedge pxlClk) begin
    if (wrEn && wrPxl <= LAST_PX)
      mem[bw][wrPxl] <= {wrRed, wrGreen, wrBlue};
  end

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      wr_line     <= '0;
      wr_done     <= '0;
      rd_line     <= '0;
      overflow    <= 1'b0;
      sameLine    <= 1'b1;
      prevLineOut <= '0;
      curLineOut  <= '0;
      nextLineOut <= '0;
    end else begin
      if (wrFrameStart) begin
        wr_line  <= '0;
        overflow <= 1'b0;
      end else begin
        if (wrLineDone && wr_line != LAST_LN)
          wr_line <= wr_line + 8'd1;
        if (wr_over)
          overflow <= 1'b1;
      end
      wr_done <= done_nxt;
      rd_line <= rd_nxt;
      if (cacheUpdate || rdFrameStart)
        sameLine <= !adv;
      prevLineOut <= {mem[bp][pp], mem[bp][p], mem[bp][pn]};
      curLineOut  <= {mem[bc][pp], mem[bc][p], mem[bc][pn]};
      nextLineOut <= {mem[bn][pp], mem[bn][p], mem[bn][pn]};
    end
  end

endmodule

// File: tb/tb_gba_line_cache.sv
// Directed bench for gba_line_cache; expectations follow the GBA_LINE_CACHE_NEIGHBOUR_EN setting.
module tb_gba_line_cache;

`ifdef GBA_LINE_CACHE_NEIGHBOUR_EN
  localparam bit NEIGH = 1'b1;
`else
  localparam bit NEIGH = 1'b0;
`endif
  localparam int LA = NEIGH ? 2 : 1;

  logic        pxlClk = 1'b0;
  logic        rst = 1'b1;
  logic        wrEn = 1'b0;
  logic [7:0]  wrPxl = '0, wrRed = '0, wrGreen = '0, wrBlue = '0;
  logic        wrLineDone = 1'b0, wrFrameStart = 1'b0, rdFrameStart = 1'b0;
  logic        nextLine = 1'b0, cacheUpdate = 1'b0;
  logic [7:0]  curPxl = '0;
  logic [71:0] prevLineOut, curLineOut, nextLineOut;
  logic        sameLine, overflow;

  int checks = 0;
  int failures = 0;
  logic [71:0] exp_cur, exp_prev, exp_next;

  gba_line_cache #(.LINE_PX(240), .LINES(160)) dut (
    .pxlClk(pxlClk), .rst(rst), .wrEn(wrEn), .wrPxl(wrPxl),
    .wrRed(wrRed), .wrGreen(wrGreen), .wrBlue(wrBlue),
    .wrLineDone(wrLineDone), .wrFrameStart(wrFrameStart),
    .rdFrameStart(rdFrameStart), .nextLine(nextLine), .cacheUpdate(cacheUpdate),
    .curPxl(curPxl), .prevLineOut(prevLineOut), .curLineOut(curLineOut),
    .nextLineOut(nextLineOut), .sameLine(sameLine), .overflow(overflow)
  );

  always #5 pxlClk = ~pxlClk;

  function automatic logic [23:0] px24(input int l, input int p);
    return {8'(l), 8'(p), 8'h55};
  endfunction

  function automatic logic [71:0] row(input int l, input int a, input int b, input int c);
    return {px24(l, a), px24(l, b), px24(l, c)};
  endfunction

  task automatic step();
    @(posedge pxlClk);
    #1;
  endtask

  task automatic write_line(input int l);
    for (int i = 0; i < 240; i++) begin
      wrEn = 1'b1; wrPxl = 8'(i); wrRed = 8'(l); wrGreen = 8'(i); wrBlue = 8'h55;
      step();
    end
    wrEn = 1'b0;
    wrLineDone = 1'b1; step(); wrLineDone = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    wrFrameStart = 1'b1; step(); wrFrameStart = 1'b0;
    repeat (3) begin wrLineDone = 1'b1; step(); wrLineDone = 1'b0; end
    rdFrameStart = 1'b1; step(); rdFrameStart = 1'b0;
    checks++; if (sameLine !== 1'b0) begin failures++; $display("FAIL setup_sameline got=%b exp=0", sameLine); end
    wrEn = 1'b1; wrPxl = 8'd5; wrRed = 8'h11; wrGreen = 8'h22; wrBlue = 8'h33;
    step();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL setup_overflow got=%b exp=1", overflow); end
    rst = 1'b1; step(); rst = 1'b0; wrEn = 1'b0;
    checks++; if (sameLine !== 1'b1) begin failures++; $display("FAIL reset_sameline got=%b exp=1", sameLine); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (prevLineOut !== 72'h0) begin failures++; $display("FAIL reset_prev got=%h exp=0", prevLineOut); end
    checks++; if (curLineOut !== 72'h0) begin failures++; $display("FAIL reset_cur got=%h exp=0", curLineOut); end
    checks++; if (nextLineOut !== 72'h0) begin failures++; $display("FAIL reset_next got=%h exp=0", nextLineOut); end
    repeat (3) begin wrLineDone = 1'b1; step(); wrLineDone = 1'b0; end
    wrFrameStart = 1'b1; wrLineDone = 1'b1; step(); wrFrameStart = 1'b0; wrLineDone = 1'b0;
    rdFrameStart = 1'b1; step(); rdFrameStart = 1'b0;
    checks++; if (sameLine !== 1'b1) begin failures++; $display("FAIL wrframe_priority got=%b exp=1", sameLine); end
  endtask

  task automatic test_advance_gating();
    wrFrameStart = 1'b1; rdFrameStart = 1'b1; step(); wrFrameStart = 1'b0; rdFrameStart = 1'b0;
    for (int l = 0; l < LA; l++) write_line(l);
    cacheUpdate = 1'b1; step(); cacheUpdate = 1'b0;
    checks++; if (sameLine !== 1'b1) begin failures++; $display("FAIL gate_sameline got=%b exp=1", sameLine); end
    curPxl = 8'd10;
    nextLine = 1'b1; step(); nextLine = 1'b0; step();
    exp_cur = NEIGH ? row(0, 9, 10, 11) : row(0, 10, 10, 10);
    checks++; if (curLineOut !== exp_cur) begin failures++; $display("FAIL gate_rdline got=%h exp=%h", curLineOut, exp_cur); end
    write_line(LA);
    checks++; if (sameLine !== 1'b1) begin failures++; $display("FAIL gate_held got=%b exp=1", sameLine); end
    cacheUpdate = 1'b1; step(); cacheUpdate = 1'b0;
    checks++; if (sameLine !== 1'b0) begin failures++; $display("FAIL adv_sameline got=%b exp=0", sameLine); end
  endtask

  task automatic test_neighbour();
    curPxl = 8'd10;
    rdFrameStart = 1'b1; step(); rdFrameStart = 1'b0; step();
    exp_cur  = NEIGH ? row(0, 9, 10, 11) : row(0, 10, 10, 10);
    exp_next = NEIGH ? row(1, 9, 10, 11) : exp_cur;
    checks++; if (sameLine !== 1'b0) begin failures++; $display("FAIL nb_sameline got=%b exp=0", sameLine); end
    checks++; if (curLineOut !== exp_cur) begin failures++; $display("FAIL nb_cur got=%h exp=%h", curLineOut, exp_cur); end
    checks++; if (prevLineOut !== exp_cur) begin failures++; $display("FAIL nb_prev got=%h exp=%h", prevLineOut, exp_cur); end
    checks++; if (nextLineOut !== exp_next) begin failures++; $display("FAIL nb_next got=%h exp=%h", nextLineOut, exp_next); end
  endtask

  task automatic test_edge_clamp();
    curPxl = 8'd0; step();
    exp_cur = NEIGH ? row(0, 0, 0, 1) : row(0, 0, 0, 0);
    checks++; if (curLineOut !== exp_cur) begin failures++; $display("FAIL clamp_px0 got=%h exp=%h", curLineOut, exp_cur); end
    curPxl = 8'd239; step();
    exp_cur = NEIGH ? row(0, 238, 239, 239) : row(0, 239, 239, 239);
    checks++; if (curLineOut !== exp_cur) begin failures++; $display("FAIL clamp_px239 got=%h exp=%h", curLineOut, exp_cur); end
    curPxl = 8'd250; step();
    checks++; if (curLineOut !== exp_cur) begin failures++; $display("FAIL clamp_px250 got=%h exp=%h", curLineOut, exp_cur); end
  endtask

  task automatic test_advance();
    curPxl = 8'd10;
    nextLine = 1'b1; step(); nextLine = 1'b0;
    exp_cur = NEIGH ? row(0, 9, 10, 11) : row(0, 10, 10, 10);
    checks++; if (curLineOut !== exp_cur) begin failures++; $display("FAIL adv_latency got=%h exp=%h", curLineOut, exp_cur); end
    step();
    exp_cur  = NEIGH ? row(1, 9, 10, 11) : row(1, 10, 10, 10);
    exp_prev = NEIGH ? row(0, 9, 10, 11) : exp_cur;
    exp_next = NEIGH ? row(2, 9, 10, 11) : exp_cur;
    checks++; if (curLineOut !== exp_cur) begin failures++; $display("FAIL adv_cur got=%h exp=%h", curLineOut, exp_cur); end
    checks++; if (prevLineOut !== exp_prev) begin failures++; $display("FAIL adv_prev got=%h exp=%h", prevLineOut, exp_prev); end
    checks++; if (nextLineOut !== exp_next) begin failures++; $display("FAIL adv_next got=%h exp=%h", nextLineOut, exp_next); end
  endtask

  task automatic test_overflow();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_initial got=%b exp=0", overflow); end
    write_line(LA + 1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_below got=%b exp=0", overflow); end
    for (int i = 0; i < 5; i++) begin
      wrEn = 1'b1; wrPxl = 8'(i); wrRed = 8'(LA + 2); wrGreen = 8'(i); wrBlue = 8'h55;
      step();
    end
    wrEn = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    repeat (10) step();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    wrFrameStart = 1'b1; step(); wrFrameStart = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_bottom();
    for (int l = 0; l < 160; l++) write_line(l);
    rdFrameStart = 1'b1; step(); rdFrameStart = 1'b0;
    repeat (159) begin nextLine = 1'b1; step(); nextLine = 1'b0; end
    // Extra line-done must saturate, so the write below still lands in line 159's bank.
    wrLineDone = 1'b1; step(); wrLineDone = 1'b0;
    wrEn = 1'b1; wrPxl = 8'd10; wrRed = 8'hAA; wrGreen = 8'h0A; wrBlue = 8'h55; step(); wrEn = 1'b0;
    curPxl = 8'd10; step(); step();
    exp_cur  = NEIGH ? {px24(159, 9), 24'hAA0A55, px24(159, 11)} : {3{24'hAA0A55}};
    exp_prev = NEIGH ? row(158, 9, 10, 11) : exp_cur;
    checks++; if (curLineOut !== exp_cur) begin failures++; $display("FAIL bot_cur got=%h exp=%h", curLineOut, exp_cur); end
    checks++; if (nextLineOut !== exp_cur) begin failures++; $display("FAIL bot_next got=%h exp=%h", nextLineOut, exp_cur); end
    checks++; if (prevLineOut !== exp_prev) begin failures++; $display("FAIL bot_prev got=%h exp=%h", prevLineOut, exp_prev); end
    cacheUpdate = 1'b1; step(); cacheUpdate = 1'b0;
    checks++; if (sameLine !== NEIGH) begin failures++; $display("FAIL bot_sameline got=%b exp=%b", sameLine, NEIGH); end
    nextLine = 1'b1; step(); nextLine = 1'b0; step();
    checks++; if (curLineOut !== exp_cur) begin failures++; $display("FAIL bot_saturate got=%h exp=%h", curLineOut, exp_cur); end
    curPxl = 8'd12;
    wrEn = 1'b1; wrPxl = 8'd12; wrRed = 8'hCC; wrGreen = 8'h0C; wrBlue = 8'h55; step(); wrEn = 1'b0;
    checks++; if (curLineOut[47:24] !== 24'h9F0C55) begin failures++; $display("FAIL rw_old got=%h exp=9f0c55", curLineOut[47:24]); end
    step();
    checks++; if (curLineOut[47:24] !== 24'hCC0C55) begin failures++; $display("FAIL rw_new got=%h exp=cc0c55", curLineOut[47:24]); end
    rdFrameStart = 1'b1; nextLine = 1'b1; step(); rdFrameStart = 1'b0; nextLine = 1'b0; step();
    checks++; if (curLineOut[47:40] !== (NEIGH ? 8'h9C : 8'h9E)) begin
      failures++; $display("FAIL rdframe_priority got=%h exp=%h", curLineOut[47:40], NEIGH ? 8'h9C : 8'h9E);
    end
    checks++; if (sameLine !== 1'b0) begin failures++; $display("FAIL rdframe_sameline got=%b exp=0", sameLine); end
  endtask

  initial begin
    test_reset();
    test_advance_gating();
    test_neighbour();
    test_edge_clamp();
    test_advance();
    test_overflow();
    test_bottom();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gba_line_cache.md
# gba_line_cache

Three-line neighbourhood cache between the GBA capture stage and the HDMI image generator. It stores captured GBA lines (240 px, 8-bit R/G/B) in a 4-bank line ring and, for the requested pixel index, returns the 3x3 neighbourhood: previous, current and next line × previous, current and next pixel. It feeds the image generator's pixel-grid and smoothing paths and tells the generator whether it may advance to the next GBA line.

## Interface
Parameters:
- LINE_PX, 240, pixels per GBA line
- LINES, 160, GBA lines per frame

Ports:
- pxlClk  in  1  pixel clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- wrEn  in  1  write strobe for one captured pixel.
- wrPxl  in  8  pixel index of the write, 0..LINE_PX-1.
- wrRed / wrGreen / wrBlue  in  8 each  pixel data.
- wrLineDone  in  1  pulse: the current write line is complete.
- wrFrameStart  in  1  pulse: capture starts a new frame.
- rdFrameStart  in  1  pulse: display starts a new frame.
- nextLine  in  1  pulse: the generator advances to the next GBA line.
- cacheUpdate  in  1  pulse once per HDMI line, at the end of the active area.
- curPxl  in  8  pixel index being read.
- prevLineOut / curLineOut / nextLineOut  out  72 each  packed {prevPxl, curPxl, nextPxl}, each {R,G,B}, MSB first.
- sameLine  out  1  1 = the generator must not advance.
- overflow  out  1  sticky: the writer overran a bank still being read.

## Operation
- Storage: 4 banks × LINE_PX × 24 bit. Write line L goes to bank L mod 4, at address wrPxl. If wrPxl ≥ LINE_PX, the write is ignored.
- Write counters:
  - wrLine (0..LINES-1) increments on wrLineDone and saturates at LINES-1.
  - wrDone (0..LINES) counts completed lines.
  - wrFrameStart clears wrLine, wrDone and overflow.
- Read line: rdLine (0..LINES-1).
  - rdFrameStart clears rdLine.
  - nextLine increments rdLine only when sameLine = 0; otherwise it is ignored.
- Line mapping:
  - The previous line reads bank (rdLine-1) mod 4, clamped to rdLine when rdLine = 0.
  - The current line reads bank rdLine mod 4.
  - The next line reads bank (rdLine+1) mod 4, clamped to rdLine when rdLine = LINES-1.
- Pixel mapping: p = min(curPxl, LINE_PX-1).
  - prev = p-1, clamped to 0.
  - next = p+1, clamped to LINE_PX-1.
- Advance rule: adv = (rdLine+2 < wrDone) or (rdLine+2 = LINES and wrDone = LINES).
  - sameLine = !adv.
  - sameLine is re-evaluated only on the cycle after cacheUpdate, or after rdFrameStart, and is held stable otherwise.
- Overflow: set when wrEn occurs while wrLine ≥ rdLine+3 (this overwrites the bank of rdLine-1). The write is still performed.
- Simultaneous events:
  - wrFrameStart together with wrLineDone: wrFrameStart wins.
  - rdFrameStart together with nextLine: rdFrameStart wins.
  - A write and a read to the same address in the same cycle return the old data.

## Timing
- Reset values: all outputs 0 except sameLine = 1; all counters 0; bank contents undefined.
- Read latency: 1 cycle. The outputs are registered copies of the neighbourhood addressed by curPxl/rdLine in the previous cycle.
- Write-to-read visibility: 1 cycle.
- sameLine updates 1 cycle after cacheUpdate. The generator samples it at the next line end, so a decision is held for one full HDMI line.
- rdLine changes on the cycle after nextLine. Outputs reflect the new line 2 cycles after nextLine.
- Reset asserted mid-line:
  - All counters and outputs return to their reset values on the next edge.
  - The first valid frame begins with wrFrameStart/rdFrameStart after reset is released.

## Configuration
- GBA_LINE_CACHE_NEIGHBOUR_EN defined: full 4-bank, 3x3 behaviour as above.
- Not defined:
  - Only 2 banks are stored (ping-pong on wrLine mod 2).
  - prevLineOut and nextLineOut mirror curLineOut.
  - The prev/next pixel fields equal the current pixel.
  - adv = (rdLine+1 < wrDone), or (rdLine = LINES-1); evaluated at the same instant as the full build.
  - Overflow threshold is wrLine ≥ rdLine+2.

## Test plan
- Reset:
  - Stimulus: assert rst mid-line.
  - Response: sameLine = 1, overflow = 0, all 72-bit outputs = 0 one edge later.
- Neighbourhood read:
  - Stimulus: write lines 0..2 with R = line, G = pixel, B = 0x55; rdFrameStart; curPxl = 10.
  - Response: after 1 cycle, curLineOut = {0,9,55, 0,10,55, 0,11,55} (hex bytes); prevLineOut equals curLineOut (top clamp); nextLineOut has R = 1.
- Edge clamp:
  - Stimulus: curPxl = 0, then 239, then 250.
  - Response: prev pixel G = 0 at curPxl 0; next pixel G = 239 at 239; 250 behaves identically to 239.
- Advance gating:
  - Stimulus: only lines 0..1 written; cacheUpdate; nextLine.
  - Response: sameLine stays 1 and rdLine stays 0.
  - Stimulus: complete line 2; cacheUpdate; nextLine.
  - Response: sameLine = 0 one cycle after cacheUpdate; rdLine becomes 1; prevLineOut R = 0, nextLineOut R = 2.
- Bottom of frame:
  - Stimulus: all 160 lines written; rdLine = 159.
  - Response: nextLineOut equals curLineOut; sameLine = 1.
- Overflow:
  - Stimulus: rdLine = 1; write pixels of line 4.
  - Response: overflow = 1 and stays 1 until wrFrameStart.
